// File: rtl/laser_shot_if.sv
// Signal bundle between the game logic and the laser shot block.
// The master side drives ticks, buttons and pixel counters; the slave owns the shot.
interface laser_shot_if;
    logic       enable;
    logic       fire;
    logic       hit;
    logic [9:0] gunPosition;
    logic [9:0] hPos;
    logic [9:0] vPos;
    logic [9:0] laserX;
    logic [9:0] laserY;
    logic       active;
    logic [2:0] color;

    modport master (
        output enable, fire, hit, gunPosition, hPos, vPos,
        input  laserX, laserY, active, color
    );

    modport slave (
        input  enable, fire, hit, gunPosition, hPos, vPos,
        output laserX, laserY, active, color
    );
endinterface

// File: rtl/laser_shot.sv
// Player laser: launches from the gun on a fire edge, climbs one step per tick,
// retires on hit or screen edge, then waits a short cooldown before re-arming.
module laser_shot #(
    parameter int SCREEN_WIDTH   = 640,
    parameter int SCREEN_HEIGHT  = 480,
    parameter int V_OFFSET       = 10,
    parameter int SHIP_HEIGHT    = 30,
    parameter int LASER_WIDTH    = 4,
    parameter int LASER_HEIGHT   = 12,
    parameter int LASER_STEP     = 8,
    parameter int COOLDOWN_TICKS = 3,
    parameter int NONE           = 7,
    parameter int LASER          = 6
) (
    input logic        clk,
    input logic        reset_n,
    laser_shot_if.slave bus
);

    localparam int CW = (COOLDOWN_TICKS < 1) ? 1 : $clog2(COOLDOWN_TICKS + 1);

    localparam logic [9:0]  START_Y = 10'(V_OFFSET + SHIP_HEIGHT);
    localparam logic [9:0]  MID_X   = 10'(SCREEN_WIDTH / 2);
    localparam logic [10:0] HALF_W  = 11'(LASER_WIDTH / 2);
    localparam logic [10:0] Y_LIMIT = 11'(SCREEN_HEIGHT - V_OFFSET);
    localparam logic [10:0] ADVANCE = 11'(LASER_STEP + LASER_HEIGHT);
    localparam logic [10:0] HEIGHT  = 11'(LASER_HEIGHT);

    typedef enum logic [1:0] {
        IDLE,
        FLYING,
        COOLDOWN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          fire_prev;
    logic          armed;

    logic          fire_edge;
    logic [10:0]   x_ext;
    logic [10:0]   y_ext;
    logic [10:0]   h_ext;
    logic [10:0]   v_ext;
    logic [10:0]   x_lo;
    logic [10:0]   x_hi;
    logic [10:0]   y_hi;
    logic [10:0]   next_bottom;
    logic          in_x;
    logic          in_y;

    // armed stays low until fire is seen released, so a button held through
    // reset cannot fire a shot on release.
    assign fire_edge = bus.fire & ~fire_prev & armed;

    always_comb begin
        x_ext       = {1'b0, bus.laserX};
        y_ext       = {1'b0, bus.laserY};
        h_ext       = {1'b0, bus.hPos};
        v_ext       = {1'b0, bus.vPos};
        x_lo        = (x_ext < HALF_W) ? 11'd0 : x_ext - HALF_W;
        x_hi        = x_ext + HALF_W;
        y_hi        = y_ext + HEIGHT;
        next_bottom = y_ext + ADVANCE;
        in_x        = (h_ext >= x_lo) && (h_ext < x_hi);
        in_y        = (v_ext >= y_ext) && (v_ext < y_hi);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            fire_prev  <= 1'b0;
            armed      <= 1'b0;
            bus.laserX <= MID_X;
            bus.laserY <= START_Y;
            bus.active <= 1'b0;
            bus.color  <= 3'(NONE);
        end else begin
            fire_prev <= bus.fire;
            if (!bus.fire) armed <= 1'b1;

            bus.color <= (bus.active && in_x && in_y) ? 3'(LASER) : 3'(NONE);

            unique case (state)
                IDLE: begin
                    if (fire_edge) begin
                        bus.laserX <= bus.gunPosition;
                        bus.laserY <= START_Y;
                        bus.active <= 1'b1;
                        state      <= FLYING;
                    end
                end
                FLYING: begin
                    if (bus.hit || (bus.enable && next_bottom > Y_LIMIT)) begin
                        bus.active <= 1'b0;
                        cnt        <= CW'(COOLDOWN_TICKS);
                        state      <= COOLDOWN;
                    end else if (bus.enable) begin
                        bus.laserY <= bus.laserY + 10'(LASER_STEP);
                    end
                end
                COOLDOWN: begin
                    if (bus.enable) begin
                        if (cnt <= CW'(1)) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                default: begin
                    bus.active <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laser_shot.sv
// Scoreboard bench for laser_shot: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_laser_shot;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    laser_shot_if bus();

    laser_shot u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string name;
        int    field;
        int    value;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        exp_t e;
        int   act;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.field)
                0:       act = int'(bus.laserX);
                1:       act = int'(bus.laserY);
                2:       act = int'(bus.active);
                default: act = int'(bus.color);
            endcase
            checks++;
            if (act != e.value) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", e.name, act, e.value);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        bus.enable = 1'b1;
        cyc(1);
        bus.enable = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_out(input string n, input int f, input int v);
        exp_t e;
        e.name  = n;
        e.field = f;
        e.value = v;
        sb.push_back(e);
    endtask

    task automatic fire_pulse();
        bus.fire = 1'b1;
        cyc(1);
        bus.fire = 1'b0;
        cyc(1);
    endtask

    task automatic hit_pulse();
        bus.hit = 1'b1;
        cyc(1);
        bus.hit = 1'b0;
    endtask

    task automatic pix(input string n, input int h, input int v, input int c);
        bus.hPos = 10'(h);
        bus.vPos = 10'(v);
        cyc(1);
        expect_out(n, 3, c);
    endtask

    initial begin
        bus.enable      = 1'b0;
        bus.fire        = 1'b0;
        bus.hit         = 1'b0;
        bus.gunPosition = 10'd0;
        bus.hPos        = 10'd0;
        bus.vPos        = 10'd0;

        cyc(2);
        expect_out("rst_x", 0, 320);
        expect_out("rst_y", 1, 40);
        expect_out("rst_active", 2, 0);
        expect_out("rst_color", 3, 7);
        reset_n = 1'b1;
        cyc(2);

        // launch and hold the button
        bus.gunPosition = 10'd200;
        bus.fire = 1'b1;
        cyc(1);
        expect_out("launch_active", 2, 1);
        expect_out("launch_x", 0, 200);
        expect_out("launch_y", 1, 40);
        cyc(100);
        expect_out("hold_active", 2, 1);
        expect_out("hold_y", 1, 40);
        bus.gunPosition = 10'd300;

        // full flight to the top edge
        for (int k = 1; k <= 52; k++) begin
            tick();
            expect_out($sformatf("fly_y%0d", k), 1, 40 + 8 * k);
        end
        expect_out("fly_x_latched", 0, 200);
        expect_out("fly_active", 2, 1);
        tick();
        expect_out("edge_active", 2, 0);
        expect_out("edge_y_hold", 1, 456);
        ticks(3);
        cyc(10);
        expect_out("held_no_relaunch", 2, 0);
        bus.fire = 1'b0;
        cyc(1);
        bus.fire = 1'b1;
        cyc(1);
        bus.fire = 1'b0;
        expect_out("relaunch_active", 2, 1);
        expect_out("relaunch_x", 0, 300);
        expect_out("relaunch_y", 1, 40);

        // hit at 104, cooldown ignores fire and hit
        ticks(8);
        expect_out("pre_hit_y", 1, 104);
        hit_pulse();
        expect_out("hit_active", 2, 0);
        expect_out("hit_y_hold", 1, 104);
        tick();
        fire_pulse();
        expect_out("cd1_fire_ignored", 2, 0);
        tick();
        fire_pulse();
        hit_pulse();
        expect_out("cd2_fire_ignored", 2, 0);
        tick();
        hit_pulse();
        expect_out("idle_hit_ignored", 2, 0);
        expect_out("idle_y_hold", 1, 104);
        bus.gunPosition = 10'd0;
        fire_pulse();
        expect_out("post_cd_active", 2, 1);
        expect_out("post_cd_x", 0, 0);
        expect_out("post_cd_y", 1, 40);

        // left-edge clamp
        pix("clamp_h0", 0, 45, 6);
        pix("clamp_h1", 1, 51, 6);
        pix("clamp_h2", 2, 45, 7);
        pix("clamp_h1023", 1023, 45, 7);
        hit_pulse();
        ticks(3);

        // pixel scan at 320,40
        bus.gunPosition = 10'd320;
        fire_pulse();
        expect_out("scan_active", 2, 1);
        expect_out("scan_x", 0, 320);
        pix("pix_318_40", 318, 40, 6);
        pix("pix_321_51", 321, 51, 6);
        pix("pix_317_40", 317, 40, 7);
        pix("pix_322_45", 322, 45, 7);
        pix("pix_320_39", 320, 39, 7);
        pix("pix_320_52", 320, 52, 7);
        hit_pulse();
        pix("idle_pix_320_45", 320, 45, 7);
        pix("idle_pix_318_40", 318, 40, 7);
        ticks(3);

        // reset mid-flight
        bus.hPos = 10'd320;
        bus.vPos = 10'd205;
        fire_pulse();
        ticks(20);
        cyc(1);
        expect_out("mid_y200", 1, 200);
        expect_out("mid_color", 3, 6);
        bus.fire = 1'b1;
        cyc(1);
        reset_n = 1'b0;
        #1;
        expect_out("mrst_active", 2, 0);
        expect_out("mrst_color", 3, 7);
        expect_out("mrst_y", 1, 40);
        expect_out("mrst_x", 0, 320);
        cyc(3);
        reset_n = 1'b1;
        cyc(5);
        expect_out("mrst_held_no_shot", 2, 0);
        bus.fire = 1'b0;
        cyc(1);
        bus.fire = 1'b1;
        cyc(1);
        bus.fire = 1'b0;
        expect_out("mrst_refire", 2, 1);
        hit_pulse();
        ticks(3);

        // hit coinciding with the final edge tick
        fire_pulse();
        ticks(52);
        expect_out("last_y456", 1, 456);
        expect_out("last_active", 2, 1);
        bus.enable = 1'b1;
        bus.hit = 1'b1;
        cyc(1);
        bus.enable = 1'b0;
        bus.hit = 1'b0;
        expect_out("both_active", 2, 0);
        expect_out("both_y", 1, 456);
        ticks(2);
        fire_pulse();
        expect_out("both_cd2_ignored", 2, 0);
        tick();
        fire_pulse();
        expect_out("both_cd3_launch", 2, 1);
        expect_out("both_cd3_y", 1, 40);

        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            cyc(1);
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
